// File: rtl/vend_pkg.sv
// vend_pkg: shared states, default widths/prices and product-select codes for the vending sequencer
package vend_pkg;
  typedef enum logic [1:0] {IDLE, CREDIT, DISPENSE, CHANGE} state_t;
  localparam int DEF_CW = 8;
  localparam int DEF_PRICE_A = 5;
  localparam int DEF_PRICE_B = 10;
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;
endpackage

// File: rtl/vend_rr_arb.sv
// vend_rr_arb: two-requester round-robin arbiter; the pointer names the product preferred on a tie
module vend_rr_arb
  import vend_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);
  logic ptr;
  always_comb grant = (&req) ? (ptr == SEL_B ? 2'b10 : 2'b01) : req;
  // after a grant the other product becomes preferred
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) ptr <= SEL_A;
    else if (advance && |grant) ptr <= grant[0] ? SEL_B : SEL_A;
endmodule

// File: rtl/vend_sequencer.sv
// vend_sequencer: coin credit, product arbitration/price check, dispense handshake and unit change return.
// Optional CREDIT_TIMEOUT_EN: refund credit after TIMEOUT idle cycles in CREDIT.
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int CW = DEF_CW,
  parameter int PRICE_A = DEF_PRICE_A,
  parameter int PRICE_B = DEF_PRICE_B,
  parameter int MAX_CREDIT = 200,
  parameter int TIMEOUT = 1000
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          coin_valid,
  input  logic [CW-1:0] coin_value,
  input  logic          selA,
  input  logic          selB,
  input  logic          cancel,
  output logic          disp_req,
  output logic          disp_sel,
  input  logic          disp_ack,
  output logic          change_pulse,
  output logic [CW-1:0] credit,
  output logic          insuff,
  output logic          busy
);
  localparam logic [CW-1:0] PA = CW'(PRICE_A);
  localparam logic [CW-1:0] PB = CW'(PRICE_B);
  localparam logic [CW-1:0] MAXC = CW'(MAX_CREDIT);
  localparam logic [CW-1:0] ONE = CW'(1);

  if (MAX_CREDIT >= (1 << CW) || TIMEOUT < 1) begin : g_bad_cfg
    $error("vend_sequencer: MAX_CREDIT must fit in CW bits and TIMEOUT must be positive");
  end

  state_t state, state_n;
  logic [CW-1:0] credit_n, price, sat;
  logic [CW:0] sum;
  logic [1:0] grant;
  logic sel, adv, tmo, cancel_eff;
  logic disp_req_n, disp_sel_n, change_n, insuff_n;

  assign sel = selA | selB;
  assign cancel_eff = cancel | tmo;
  assign adv = state == CREDIT && !cancel_eff && sel;
  assign sum = {1'b0, credit} + {1'b0, coin_value};
  assign sat = (sum > {1'b0, MAXC}) ? MAXC : sum[CW-1:0];
  assign price = grant[1] ? PB : PA;

  vend_rr_arb u_arb (
    .clk(clk),
    .reset_n(reset_n),
    .req({selB, selA}),
    .advance(adv),
    .grant(grant)
  );

`ifdef CREDIT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT) + 1;
  logic [TW-1:0] tcnt;
  logic idle_c;
  assign idle_c = state == CREDIT && !coin_valid && !sel && !cancel;
  assign tmo = idle_c && tcnt == TW'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) tcnt <= '0;
    else tcnt <= (idle_c && !tmo) ? tcnt + TW'(1) : '0;
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_n = state;
    credit_n = credit;
    disp_req_n = disp_req;
    disp_sel_n = disp_sel;
    change_n = 1'b0;
    insuff_n = 1'b0;
    case (state)
      IDLE:
        if (sel) insuff_n = 1'b1;
        else if (coin_valid) begin
          credit_n = sat;
          state_n = CREDIT;
        end
      CREDIT:
        if (cancel_eff) begin
          state_n = (credit != '0) ? CHANGE : IDLE;
          change_n = credit != '0;
          credit_n = (credit != '0) ? credit - ONE : credit;
        end else if (sel) begin
          if (credit >= price) begin
            credit_n = credit - price;
            disp_req_n = 1'b1;
            disp_sel_n = grant[1] ? SEL_B : SEL_A;
            state_n = DISPENSE;
          end else insuff_n = 1'b1;
        end else if (coin_valid) credit_n = sat;
      DISPENSE:
        if (disp_ack) begin
          disp_req_n = 1'b0;
          disp_sel_n = 1'b0;
          state_n = (credit != '0) ? CHANGE : IDLE;
          change_n = credit != '0;
          credit_n = (credit != '0) ? credit - ONE : credit;
        end
      CHANGE:
        if (credit != '0) begin
          change_n = 1'b1;
          credit_n = credit - ONE;
        end else state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      credit <= '0;
      disp_req <= 1'b0;
      disp_sel <= 1'b0;
      change_pulse <= 1'b0;
      insuff <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      credit <= credit_n;
      disp_req <= disp_req_n;
      disp_sel <= disp_sel_n;
      change_pulse <= change_n;
      insuff <= insuff_n;
      busy <= state_n == DISPENSE || state_n == CHANGE;
    end
endmodule
